mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Single-port memory controller that shares one memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores). It arbitrates with data-over-instruction priority and a starvation guard, sequences one outstanding transaction at a time through a small FSM, and returns per-requester response pulses and stall signals. It sits between the fetch/memory pipeline stages and the unified memory interface.

## Interface

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while fetch is pending before fetch is forced (≥1)

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- if_req_i  in  1  fetch read request; level, held until if_rvalid_o
- if_addr_i  in  ADDR_W  fetch address
- if_flush_i  in  1  cancel the fetch transaction in flight
- if_rvalid_o  out  1  one-cycle fetch response pulse
- if_rdata_o  out  DATA_W  fetch read data, valid with if_rvalid_o
- if_stall_o  out  1  if_req_i & ~if_rvalid_o
- dm_req_i  in  1  data request; level, held until dm_rvalid_o
- dm_we_i  in  1  1 = store, 0 = load
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  store data
- dm_be_i  in  DATA_W/8  store byte enables
- dm_rvalid_o  out  1  one-cycle data response pulse (load data or store ack)
- dm_rdata_o  out  DATA_W  load data
- dm_stall_o  out  1  dm_req_i & ~dm_rvalid_o
- mem_req_o  out  1  memory request
- mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o  out  1/ADDR_W/DATA_W/DATA_W/8  latched request fields
- mem_gnt_i  in  1  memory accepted request this cycle
- mem_rvalid_i  in  1  memory response (read data or write ack)
- mem_rdata_i  in  DATA_W  memory read data

## Operation

- FSM states: IDLE, REQ, WAIT, RESP. Source register src ∈ {IF, DM}.
- IDLE: if any request, pick the winner, latch its fields into mem_* registers, set src, go to REQ. Otherwise stay.
- Priority: DM wins over IF, except when starve_cnt == STARVE_MAX and if_req_i is high, in which case IF wins.
- starve_cnt increments on each DM grant while if_req_i is high, saturates at STARVE_MAX, and clears on an IF grant.
- REQ: mem_req_o=1. If mem_gnt_i && mem_rvalid_i, go to RESP. If mem_gnt_i only, go to WAIT.
- WAIT: mem_req_o=0. If mem_rvalid_i, capture mem_rdata_i and go to RESP.
- RESP: pulse the src rvalid with captured data, then return to IDLE. Requests are not sampled in RESP, so a held request is never re-issued.
- Flush: if_flush_i high while src=IF in REQ/WAIT (or coincident with the capture) sets a discard flag. The transaction still completes on memory, but if_rvalid_o is suppressed. The flag clears in RESP. Flush is ignored in IDLE and when src=DM.
- mem_rvalid_i is ignored in IDLE, REQ-without-gnt and RESP.
- Stores have mem_we_o=1, and dm_rdata_o is don't-care on the ack.

## Timing

- Reset (async assert): state=IDLE, starve_cnt=0, discard=0. All registered outputs are 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, if_rvalid_o, dm_rvalid_o, if_rdata_o, dm_rdata_o. Reset mid-transaction abandons it, and a late mem_rvalid_i after reset is ignored.
- Minimum latency, request seen in IDLE at cycle 0: mem_req_o in cycle 1; gnt+rvalid in cycle 1 gives rvalid_o in cycle 2. Gnt in 1 and rvalid in 2 gives rvalid_o in cycle 3.
- Back-to-back: the next grant is decided in the IDLE cycle following RESP.
- mem_* fields are stable from REQ entry until the return to IDLE.
- Stalls are combinational from req/rvalid.

## Structure

- Package mem_arb_pkg: state_t enum (IDLE, REQ, WAIT, RESP), src_t enum (SRC_IF, SRC_DM).
- Sub-module mem_arb_prio: combinational winner select plus starve_cnt register.
- Top module holds the FSM, field latches and response registers.

## Test plan

- Single fetch: if_req_i=1 with addr 0x100; memory gnt in cycle 1 and rvalid in cycle 2 with 0xDEADBEEF. Expect if_rvalid_o in cycle 3 with that data, if_stall_o high cycles 0–2, and mem_req_o only in cycle 1.
- Collision: both requests at cycle 0, dm store 0x200/0x1234 with be=0xF. Expect the DM transaction first (mem_we_o=1), then the IF transaction. if_stall_o stays high throughout.
- Starvation: if_req_i held while dm_req_i is re-asserted every cycle, STARVE_MAX=4. Expect exactly 4 DM grants, then an IF grant, then starve_cnt=0.
- Flush: IF grant, memory withholds rvalid; pulse if_flush_i in WAIT, rvalid arrives 3 cycles later. Expect no if_rvalid_o, return to IDLE, and a subsequent DM request served normally.
- Wait states: gnt delayed 5 cycles. Expect mem_req_o and mem_addr_o held constant for all 5 cycles and a single transaction issued.
- Reset mid-WAIT: assert rst_i, then inject mem_rvalid_i after release. Expect all outputs 0 and no rvalid pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//   state_t : transaction sequencer states
//   src_t   : which requester owns the transaction in flight
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_DM = 1'b1
  } src_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of all handshake and bus signals around the memory port arbiter.
//   slave  : arbiter view (fetch/data requests and memory responses in; responses,
//            stalls and the memory request out)
//   master : environment view (fetch stage, memory stage and memory together)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Fetch stage
  logic                  if_req_i;
  logic [ADDR_W-1:0]     if_addr_i;
  logic                  if_flush_i;
  logic                  if_rvalid_o;
  logic [DATA_W-1:0]     if_rdata_o;
  logic                  if_stall_o;
  // Memory stage
  logic                  dm_req_i;
  logic                  dm_we_i;
  logic [ADDR_W-1:0]     dm_addr_i;
  logic [DATA_W-1:0]     dm_wdata_i;
  logic [DATA_W/8-1:0]   dm_be_i;
  logic                  dm_rvalid_o;
  logic [DATA_W-1:0]     dm_rdata_o;
  logic                  dm_stall_o;
  // Unified memory
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_W-1:0]     mem_wdata_o;
  logic [DATA_W/8-1:0]   mem_be_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [DATA_W-1:0]     mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_be_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output if_rvalid_o, if_rdata_o, if_stall_o,
    output dm_rvalid_o, dm_rdata_o, dm_stall_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_be_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  if_rvalid_o, if_rdata_o, if_stall_o,
    input  dm_rvalid_o, dm_rdata_o, dm_stall_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );

endinterface

// File: rtl/mem_arb_prio.sv
// Winner select for the shared memory port: data over fetch, except that fetch is
// forced once STARVE_MAX data grants have gone by while fetch was waiting.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   if_req_i       : fetch request level
//   dm_req_i       : data request level
//   grant_en_i     : arbiter is able to start a transaction this cycle
//   grant_valid_o  : some requester is asking
//   grant_src_o    : winning requester
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic if_req_i,
  input  logic dm_req_i,
  input  logic grant_en_i,
  output logic grant_valid_o,
  output src_t grant_src_o
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  logic [CntW-1:0] r_starve_cnt;
  logic            w_starved;
  logic            w_if_win;

  assign w_starved     = (r_starve_cnt == CntMax);
  assign w_if_win      = if_req_i & (~dm_req_i | w_starved);
  assign grant_valid_o = if_req_i | dm_req_i;
  assign grant_src_o   = w_if_win ? SRC_IF : SRC_DM;

  // Counts data grants that bypassed a waiting fetch; saturates, cleared by a fetch grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_starve_cnt <= '0;
    end else if (grant_en_i && grant_valid_o) begin
      if (w_if_win) begin
        r_starve_cnt <= '0;
      end else if (if_req_i && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access. One transaction
// is outstanding at a time; its fields are latched at grant and held until the
// arbiter returns to IDLE. Responses come back as one-cycle pulses to the owner.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : mem_port_arbiter_if.slave (fetch, data and memory handshakes)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned BeW = DATA_W / 8;

  state_t              r_state;
  src_t                r_src;
  logic                r_discard;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [BeW-1:0]      r_mem_be;
  logic                r_if_rvalid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic                r_dm_rvalid;
  logic [DATA_W-1:0]   r_dm_rdata;

  logic                w_grant_en;
  logic                w_grant_valid;
  src_t                w_grant_src;
  logic                w_flush_now;
  logic                w_capture;

  assign w_grant_en = (r_state == IDLE);

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .if_req_i      (bus.if_req_i),
    .dm_req_i      (bus.dm_req_i),
    .grant_en_i    (w_grant_en),
    .grant_valid_o (w_grant_valid),
    .grant_src_o   (w_grant_src)
  );

  // A flush only matters while a fetch owns the port; covers the capture cycle too.
  assign w_flush_now = bus.if_flush_i && (r_src == SRC_IF) &&
                       ((r_state == REQ) || (r_state == WAIT));

  // mem_rvalid_i is only meaningful once the request has been granted.
  assign w_capture = bus.mem_rvalid_i &&
                     (((r_state == REQ) && bus.mem_gnt_i) || (r_state == WAIT));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_src       <= SRC_IF;
      r_discard   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rvalid <= 1'b0;
      r_dm_rdata  <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      if (w_flush_now) begin
        r_discard <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_src     <= w_grant_src;
            r_mem_req <= 1'b1;
            r_state   <= REQ;
            if (w_grant_src == SRC_DM) begin
              r_mem_we    <= bus.dm_we_i;
              r_mem_addr  <= bus.dm_addr_i;
              r_mem_wdata <= bus.dm_wdata_i;
              r_mem_be    <= bus.dm_be_i;
            end else begin
              r_mem_we    <= 1'b0;
              r_mem_addr  <= bus.if_addr_i;
              r_mem_wdata <= '0;
              r_mem_be    <= '0;
            end
          end
        end
        REQ: begin
          if (bus.mem_gnt_i) begin
            r_mem_req <= 1'b0;
            r_state   <= bus.mem_rvalid_i ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid_i) begin
            r_state <= RESP;
          end
        end
        RESP: begin
          r_discard <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // Response registers load on the transition into RESP so the pulse lines up with it.
      if (w_capture) begin
        if (r_src == SRC_DM) begin
          r_dm_rvalid <= 1'b1;
          r_dm_rdata  <= bus.mem_rdata_i;
        end else if (!r_discard && !w_flush_now) begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= bus.mem_rdata_i;
        end
      end
    end
  end

  assign bus.mem_req_o   = r_mem_req;
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_wdata_o = r_mem_wdata;
  assign bus.mem_be_o    = r_mem_be;
  assign bus.if_rvalid_o = r_if_rvalid;
  assign bus.if_rdata_o  = r_if_rdata;
  assign bus.dm_rvalid_o = r_dm_rvalid;
  assign bus.dm_rdata_o  = r_dm_rdata;
  assign bus.if_stall_o  = bus.if_req_i & ~r_if_rvalid;
  assign bus.dm_stall_o  = bus.dm_req_i & ~r_dm_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic clear_inputs();
    bus.if_req_i     = 1'b0;
    bus.if_addr_i    = '0;
    bus.if_flush_i   = 1'b0;
    bus.dm_req_i     = 1'b0;
    bus.dm_we_i      = 1'b0;
    bus.dm_addr_i    = '0;
    bus.dm_wdata_i   = '0;
    bus.dm_be_i      = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk($sformatf("%s mem_req", tag), bus.mem_req_o, 0);
    chk($sformatf("%s mem_we", tag), bus.mem_we_o, 0);
    chk($sformatf("%s mem_addr", tag), bus.mem_addr_o, 0);
    chk($sformatf("%s mem_wdata", tag), bus.mem_wdata_o, 0);
    chk($sformatf("%s mem_be", tag), bus.mem_be_o, 0);
    chk($sformatf("%s if_rvalid", tag), bus.if_rvalid_o, 0);
    chk($sformatf("%s dm_rvalid", tag), bus.dm_rvalid_o, 0);
    chk($sformatf("%s if_rdata", tag), bus.if_rdata_o, 0);
    chk($sformatf("%s dm_rdata", tag), bus.dm_rdata_o, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One isolated transaction: memory grants in cycle 1+g, responds r cycles after the grant.
  typedef struct {
    bit          is_dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          g;
    int          r;
    bit          noise;     // spurious mem_rvalid_i in IDLE and REQ-without-gnt
    logic [31:0] rdata;
    int          exp_rv;    // cycle of the response pulse
    int          exp_last;  // last cycle with mem_req_o high
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    bit exp_req;
    for (int c = 0; c <= v.exp_rv + 1; c++) begin
      tick();
      bus.if_req_i     = !v.is_dm && (c <= v.exp_rv);
      bus.dm_req_i     = v.is_dm && (c <= v.exp_rv);
      bus.if_addr_i    = v.addr;
      bus.dm_addr_i    = v.addr;
      bus.dm_we_i      = v.we;
      bus.dm_wdata_i   = v.wdata;
      bus.dm_be_i      = v.be;
      bus.mem_gnt_i    = (c == 1 + v.g);
      bus.mem_rvalid_i = (c == 1 + v.g + v.r) || (v.noise && (c < 1 + v.g));
      bus.mem_rdata_i  = (c == 1 + v.g + v.r) ? v.rdata : 32'h0BAD_0BAD;
      mid();
      exp_req = (c >= 1) && (c <= v.exp_last);
      chk($sformatf("vec%0d c%0d mem_req", idx, c), bus.mem_req_o, exp_req);
      if (c >= 1 && c <= v.exp_rv) begin
        chk($sformatf("vec%0d c%0d mem_addr", idx, c), bus.mem_addr_o, v.addr);
        chk($sformatf("vec%0d c%0d mem_we", idx, c), bus.mem_we_o, v.we);
        if (v.we) begin
          chk($sformatf("vec%0d c%0d mem_wdata", idx, c), bus.mem_wdata_o, v.wdata);
          chk($sformatf("vec%0d c%0d mem_be", idx, c), bus.mem_be_o, v.be);
        end
      end
      if (v.is_dm) begin
        chk($sformatf("vec%0d c%0d dm_rvalid", idx, c), bus.dm_rvalid_o, c == v.exp_rv);
        chk($sformatf("vec%0d c%0d if_rvalid", idx, c), bus.if_rvalid_o, 0);
        chk($sformatf("vec%0d c%0d dm_stall", idx, c), bus.dm_stall_o, c < v.exp_rv);
        if (c == v.exp_rv && !v.we)
          chk($sformatf("vec%0d dm_rdata", idx), bus.dm_rdata_o, v.rdata);
      end else begin
        chk($sformatf("vec%0d c%0d if_rvalid", idx, c), bus.if_rvalid_o, c == v.exp_rv);
        chk($sformatf("vec%0d c%0d dm_rvalid", idx, c), bus.dm_rvalid_o, 0);
        chk($sformatf("vec%0d c%0d if_stall", idx, c), bus.if_stall_o, c < v.exp_rv);
        if (c == v.exp_rv)
          chk($sformatf("vec%0d if_rdata", idx), bus.if_rdata_o, v.rdata);
      end
    end
  endtask

  vec_t vecs[6];

  // Random-phase state
  logic [31:0] mem_arr [32];
  logic [31:0] gold    [32];
  bit          if_pend, dm_pend, dm_w, prev_if, prev_dm, prev_mreq, outst, exp_if, act_if;
  logic [31:0] if_a, dm_a, dm_wd, rv_data;
  logic [3:0]  dm_b;
  int          if_age, dm_age, starve, rv_cnt, gnt_wait, idx;
  int          grants[$];

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;

    // ---------------- table-driven single transactions ----------------
    vecs[0] = '{0, 0, 32'h100, 0, 4'h0, 0, 1, 0, 32'hDEADBEEF, 3, 1};
    vecs[1] = '{0, 0, 32'h104, 0, 4'h0, 0, 0, 0, 32'h01234567, 2, 1};
    vecs[2] = '{0, 0, 32'h108, 0, 4'h0, 5, 0, 1, 32'hA5A5A5A5, 7, 6};
    vecs[3] = '{1, 0, 32'h200, 0, 4'h0, 1, 2, 0, 32'h5555AAAA, 5, 2};
    vecs[4] = '{1, 1, 32'h204, 32'h00001234, 4'hF, 0, 0, 0, 32'h0, 2, 1};
    vecs[5] = '{1, 1, 32'h208, 32'hCAFEBABE, 4'h5, 2, 3, 1, 32'h0, 7, 3};
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // ---------------- collision: DM store first, then IF ----------------
    do_reset();
    tick();
    bus.if_req_i = 1; bus.if_addr_i = 32'h100;
    bus.dm_req_i = 1; bus.dm_we_i = 1; bus.dm_addr_i = 32'h200;
    bus.dm_wdata_i = 32'h1234; bus.dm_be_i = 4'hF;
    mid();
    chk("coll c0 mem_req", bus.mem_req_o, 0);
    chk("coll c0 if_stall", bus.if_stall_o, 1);
    tick(); bus.mem_gnt_i = 1; bus.mem_rvalid_i = 1; mid();
    chk("coll c1 mem_addr", bus.mem_addr_o, 32'h200);
    chk("coll c1 mem_we", bus.mem_we_o, 1);
    chk("coll c1 mem_wdata", bus.mem_wdata_o, 32'h1234);
    tick(); bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; mid();
    chk("coll c2 dm_rvalid", bus.dm_rvalid_o, 1);
    chk("coll c2 if_rvalid", bus.if_rvalid_o, 0);
    chk("coll c2 if_stall", bus.if_stall_o, 1);
    tick(); bus.dm_req_i = 0; mid();
    chk("coll c3 mem_req", bus.mem_req_o, 0);
    chk("coll c3 if_stall", bus.if_stall_o, 1);
    tick(); bus.mem_gnt_i = 1; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hCAFEF00D; mid();
    chk("coll c4 mem_req", bus.mem_req_o, 1);
    chk("coll c4 mem_addr", bus.mem_addr_o, 32'h100);
    chk("coll c4 mem_we", bus.mem_we_o, 0);
    chk("coll c4 if_stall", bus.if_stall_o, 1);
    tick(); bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; mid();
    chk("coll c5 if_rvalid", bus.if_rvalid_o, 1);
    chk("coll c5 if_rdata", bus.if_rdata_o, 32'hCAFEF00D);
    chk("coll c5 if_stall", bus.if_stall_o, 0);

    // ---------------- starvation guard ----------------
    do_reset();
    bus.if_addr_i = 32'h100; bus.dm_addr_i = 32'h300;
    grants.delete();
    for (int c = 0; c < 40; c++) begin
      tick();
      bus.if_req_i     = 1;
      bus.dm_req_i     = 1;
      bus.mem_gnt_i    = bus.mem_req_o;
      bus.mem_rvalid_i = bus.mem_req_o;
      if (bus.mem_req_o) grants.push_back((bus.mem_addr_o == 32'h100) ? 1 : 0);
    end
    chk("starve grant count >= 10", grants.size() >= 10, 1);
    for (int i = 0; i < 10 && i < grants.size(); i++)
      chk($sformatf("starve grant%0d is_if", i), grants[i], (i == 4 || i == 9) ? 1 : 0);

    // ---------------- flush in WAIT ----------------
    do_reset();
    tick(); bus.if_req_i = 1; bus.if_addr_i = 32'h140; mid();
    tick(); bus.mem_gnt_i = 1; mid();
    chk("flush c1 mem_req", bus.mem_req_o, 1);
    tick(); bus.mem_gnt_i = 0; bus.if_flush_i = 1; mid();
    chk("flush c2 mem_req", bus.mem_req_o, 0);
    tick(); bus.if_flush_i = 0; bus.if_req_i = 0; mid();
    tick(); mid();
    tick(); bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h11111111; mid();
    chk("flush c5 if_rvalid", bus.if_rvalid_o, 0);
    tick(); bus.mem_rvalid_i = 0; mid();
    chk("flush c6 if_rvalid", bus.if_rvalid_o, 0);
    chk("flush c6 mem_req", bus.mem_req_o, 0);
    tick(); bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h180; mid();
    chk("flush c7 if_rvalid", bus.if_rvalid_o, 0);
    tick(); bus.mem_gnt_i = 1; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h2222; mid();
    chk("flush c8 mem_req", bus.mem_req_o, 1);
    chk("flush c8 mem_addr", bus.mem_addr_o, 32'h180);
    tick(); bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; mid();
    chk("flush c9 dm_rvalid", bus.dm_rvalid_o, 1);
    chk("flush c9 dm_rdata", bus.dm_rdata_o, 32'h2222);
    chk("flush c9 if_rvalid", bus.if_rvalid_o, 0);

    // ---------------- reset mid-WAIT ----------------
    do_reset();
    tick(); bus.if_req_i = 1; bus.if_addr_i = 32'h1C0; mid();
    tick(); bus.mem_gnt_i = 1; mid();
    chk("rstw c1 mem_addr", bus.mem_addr_o, 32'h1C0);
    tick(); bus.mem_gnt_i = 0; mid();
    chk("rstw c2 mem_req", bus.mem_req_o, 0);
    #1; rst = 1; bus.if_req_i = 0; #1;
    chk_zero("rstw async");
    tick(); rst = 0; mid();
    tick(); bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h77777777; mid();
    tick(); bus.mem_rvalid_i = 0; mid();
    chk_zero("rstw late rvalid");

    // ---------------- randomized traffic vs reference model ----------------
    do_reset();
    for (int i = 0; i < 32; i++) begin
      mem_arr[i] = $urandom;
      gold[i]    = mem_arr[i];
    end
    if_pend = 0; dm_pend = 0; prev_if = 0; prev_dm = 0; prev_mreq = 0; outst = 0;
    starve = 0; gnt_wait = 0; rv_cnt = 0; if_age = 0; dm_age = 0;
    if_a = 0; dm_a = 32'h40; dm_w = 0; dm_wd = 0; dm_b = 0; rv_data = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_age = 0;
        if_a = 32'($urandom_range(0, 15)) << 2;
      end
      if (!dm_pend && $urandom_range(0, 2) == 0) begin
        dm_pend = 1; dm_age = 0;
        dm_a  = 32'h40 | (32'($urandom_range(0, 15)) << 2);
        dm_w  = 1'($urandom_range(0, 1));
        dm_wd = $urandom;
        dm_b  = 4'($urandom_range(0, 15));
      end
      bus.if_req_i = if_pend; bus.if_addr_i = if_a;
      bus.dm_req_i = dm_pend; bus.dm_addr_i = dm_a; bus.dm_we_i = dm_w;
      bus.dm_wdata_i = dm_wd; bus.dm_be_i = dm_b;
      // memory: random grant delay (bounded), response 0..2 cycles after grant
      bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = $urandom;
      if (bus.mem_req_o) begin
        gnt_wait++;
        if ($urandom_range(0, 1) == 1 || gnt_wait > 4) begin
          bus.mem_gnt_i = 1; gnt_wait = 0;
          idx = int'(bus.mem_addr_o[6:2]);
          rv_data = mem_arr[idx];
          if (bus.mem_we_o)
            for (int b = 0; b < 4; b++)
              if (bus.mem_be_o[b]) mem_arr[idx][8*b +: 8] = bus.mem_wdata_o[8*b +: 8];
          rv_cnt = $urandom_range(0, 2);
          outst = 1;
        end
      end
      if (outst) begin
        if (rv_cnt == 0) begin
          bus.mem_rvalid_i = 1; bus.mem_rdata_i = rv_data; outst = 0;
        end else begin
          rv_cnt--;
        end
      end else if (!bus.mem_req_o && $urandom_range(0, 7) == 0) begin
        bus.mem_rvalid_i = 1;
      end
      mid();
      if (bus.mem_req_o && !prev_mreq) begin
        chk("rand grant had request", prev_if | prev_dm, 1);
        exp_if = (prev_if && prev_dm) ? (starve == SMAX) : prev_if;
        act_if = (bus.mem_addr_o[6] == 1'b0);
        chk($sformatf("rand cyc%0d winner is_if", cyc), act_if, exp_if);
        if (exp_if) begin
          chk("rand if mem_addr", bus.mem_addr_o, if_a);
          chk("rand if mem_we", bus.mem_we_o, 0);
          starve = 0;
        end else begin
          chk("rand dm mem_addr", bus.mem_addr_o, dm_a);
          chk("rand dm mem_we", bus.mem_we_o, dm_w);
          if (dm_w) begin
            chk("rand dm mem_wdata", bus.mem_wdata_o, dm_wd);
            chk("rand dm mem_be", bus.mem_be_o, dm_b);
          end
          if (prev_if && starve < SMAX) starve++;
        end
      end
      if (bus.if_rvalid_o) begin
        chk("rand if_rvalid with pending req", if_pend, 1);
        chk("rand if_rdata", bus.if_rdata_o, gold[if_a[6:2]]);
        if_pend = 0;
      end
      if (bus.dm_rvalid_o) begin
        chk("rand dm_rvalid with pending req", dm_pend, 1);
        if (!dm_w) chk("rand dm_rdata", bus.dm_rdata_o, gold[dm_a[6:2]]);
        else
          for (int b = 0; b < 4; b++)
            if (dm_b[b]) gold[dm_a[6:2]][8*b +: 8] = dm_wd[8*b +: 8];
        dm_pend = 0;
      end
      if (if_pend) if_age++;
      if (dm_pend) dm_age++;
      if (if_age > 300) begin
        n_cmp++; n_fail++;
        $display("FAIL rand if timeout: waited %0d cycles, limit 300", if_age);
        if_pend = 0; if_age = 0;
      end
      if (dm_age > 300) begin
        n_cmp++; n_fail++;
        $display("FAIL rand dm timeout: waited %0d cycles, limit 300", dm_age);
        dm_pend = 0; dm_age = 0;
      end
      prev_if   = bus.if_req_i;
      prev_dm   = bus.dm_req_i;
      prev_mreq = bus.mem_req_o;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
